// File: rtl/latq_bank_pkg.sv
// Shared types and constants for the latch-bank write controller.
// The FSM encoding and the timer width are fixed here so the top and the timer agree.
package latq_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // The FSM spends exactly one cycle in SETUP and in HOLD.
    localparam int SETUP_CYC = 1;
    localparam int HOLD_CYC  = 1;

    localparam int TIMER_W     = 4;
    localparam int PULSE_MAX   = (1 << TIMER_W) - 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/latq_bank_pulse_timer.sv
// Loadable down-counter that times how long the latch E line stays high.
// Load wins over enable; the count parks at zero and reports it on zero.
module latq_bank_pulse_timer
    import latq_bank_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic               en,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] count_reg;
    logic [TIMER_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (en && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/latq_bank_wr_ctrl.sv
// Write controller for a bank of level-sensitive latches: turns a valid/ready request
// into a registered one-hot E pulse framed by whole-cycle D setup and hold windows.
module latq_bank_wr_ctrl
    import latq_bank_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int AW        = 3,
    parameter int PULSE_CYC = 2
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] lat_d,
    output logic [DEPTH-1:0] lat_e,
    output logic             busy,
    output logic             wr_err
);

    generate
        if (PULSE_CYC < 1 || PULSE_CYC > PULSE_MAX) begin : g_bad_pulse
            $error("latq_bank_wr_ctrl: PULSE_CYC must be in 1..15");
        end
        if (clog2(DEPTH) > AW) begin : g_bad_aw
            $error("latq_bank_wr_ctrl: AW too narrow for DEPTH");
        end
        if (SETUP_CYC != 1 || HOLD_CYC != 1) begin : g_bad_frame
            $error("latq_bank_wr_ctrl: SETUP and HOLD are single-cycle states");
        end
    endgenerate

    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYC - 1);
    localparam logic [AW:0]        DEPTH_W    = (AW + 1)'(DEPTH);

    state_t             state_reg;
    state_t             state_next;
    logic [AW-1:0]      addr_reg;
    logic [AW-1:0]      addr_next;
    logic [WIDTH-1:0]   lat_d_reg;
    logic [WIDTH-1:0]   lat_d_next;
    logic [DEPTH-1:0]   lat_e_reg;
    logic [DEPTH-1:0]   lat_e_next;
    logic               wr_err_reg;
    logic               wr_err_next;
    logic               busy_reg;
    logic               busy_next;

    logic [DEPTH-1:0]   addr_onehot;
    logic               addr_in_range;
    logic               timer_zero;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign addr_onehot[gi] = (addr_reg == AW'(gi));
        end
    endgenerate

    assign addr_in_range = ({1'b0, addr_reg} < DEPTH_W);

    latq_bank_pulse_timer u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (state_reg == SETUP),
        .en       (state_reg == PULSE),
        .load_val (PULSE_LOAD),
        .zero     (timer_zero)
    );

    // State and every output live in flops; E is never driven by the decode directly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            lat_d_reg  <= '0;
            lat_e_reg  <= '0;
            wr_err_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            lat_d_reg  <= lat_d_next;
            lat_e_reg  <= lat_e_next;
            wr_err_reg <= wr_err_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (wr_valid) state_next = SETUP;
            SETUP:   state_next = addr_in_range ? PULSE : HOLD;
            PULSE:   if (timer_zero) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        addr_next   = addr_reg;
        lat_d_next  = lat_d_reg;
        lat_e_next  = lat_e_reg;
        wr_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                lat_e_next = '0;
                if (wr_valid) begin
                    addr_next  = wr_addr;
                    lat_d_next = wr_data;
                end
            end
            SETUP: begin
                // Out-of-range targets skip the pulse entirely and only flag the error.
                lat_e_next  = addr_in_range ? addr_onehot : '0;
                wr_err_next = !addr_in_range;
            end
            PULSE: begin
                if (timer_zero) lat_e_next = '0;
            end
            HOLD: begin
                lat_e_next = '0;
            end
            default: begin
                lat_e_next = '0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    assign lat_d    = lat_d_reg;
    assign lat_e    = lat_e_reg;
    assign wr_err   = wr_err_reg;
    assign busy     = busy_reg;
    assign wr_ready = !busy_reg && !RST;

    lat_e_onehot0: assert property (@(posedge CLK) disable iff (RST) $onehot0(lat_e_reg));

endmodule

// File: tb/tb_latq_bank_wr_ctrl.sv
// Directed bench for latq_bank_wr_ctrl: vector table on the PULSE_CYC=2 bank, plus
// reset, back-to-back, out-of-range and pulse-width sequences on three instances.
module tb_latq_bank_wr_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Instance A: DEPTH 8, PULSE_CYC 2
    logic       a_valid, a_ready, a_busy, a_err;
    logic [2:0] a_addr;
    logic [7:0] a_data, a_d, a_e;
    // Instance B: DEPTH 6, PULSE_CYC 1
    logic       b_valid, b_ready, b_busy, b_err;
    logic [2:0] b_addr;
    logic [7:0] b_data, b_d;
    logic [5:0] b_e;
    // Instance C: DEPTH 8, PULSE_CYC 15
    logic       c_valid, c_ready, c_busy, c_err;
    logic [2:0] c_addr;
    logic [7:0] c_data, c_d, c_e;

    latq_bank_wr_ctrl #(.DEPTH(8), .WIDTH(8), .AW(3), .PULSE_CYC(2)) dut_a (
        .CLK(CLK), .RST(RST), .wr_valid(a_valid), .wr_ready(a_ready), .wr_addr(a_addr),
        .wr_data(a_data), .lat_d(a_d), .lat_e(a_e), .busy(a_busy), .wr_err(a_err));
    latq_bank_wr_ctrl #(.DEPTH(6), .WIDTH(8), .AW(3), .PULSE_CYC(1)) dut_b (
        .CLK(CLK), .RST(RST), .wr_valid(b_valid), .wr_ready(b_ready), .wr_addr(b_addr),
        .wr_data(b_data), .lat_d(b_d), .lat_e(b_e), .busy(b_busy), .wr_err(b_err));
    latq_bank_wr_ctrl #(.DEPTH(8), .WIDTH(8), .AW(3), .PULSE_CYC(15)) dut_c (
        .CLK(CLK), .RST(RST), .wr_valid(c_valid), .wr_ready(c_ready), .wr_addr(c_addr),
        .wr_data(c_data), .lat_d(c_d), .lat_e(c_e), .busy(c_busy), .wr_err(c_err));

    // Latch model for bank A, sampled mid-cycle when D and E are stable.
    logic [7:0] mem_a [8] = '{default: 8'h00};
    always @(negedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (a_e[i]) mem_a[i] <= a_d;
        end
    end

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp_e;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_mem [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s: got 0x%0h ok", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One write on bank A with cycle-exact checks of the PULSE_CYC=2 timeline.
    task automatic write_a(input logic [2:0] addr, input logic [7:0] data,
                           input logic [7:0] exp_e, input string tag);
        int n;
        n = 0;
        while (!a_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " ready-before"}, 32'(a_ready), 32'd1);
        a_valid = 1'b1;
        a_addr  = addr;
        a_data  = data;
        tick();
        a_valid = 1'b0;
        a_addr  = 3'($urandom);
        a_data  = 8'($urandom);
        chk({tag, " d@e0"}, 32'(a_d), 32'(data));
        chk({tag, " e@e0"}, 32'(a_e), 32'd0);
        chk({tag, " ready@e0"}, 32'(a_ready), 32'd0);
        tick();
        chk({tag, " e@e1"}, 32'(a_e), 32'(exp_e));
        chk({tag, " err@e1"}, 32'(a_err), 32'd0);
        tick();
        chk({tag, " e@e2"}, 32'(a_e), 32'(exp_e));
        tick();
        chk({tag, " e@e3"}, 32'(a_e), 32'd0);
        chk({tag, " ready@e3"}, 32'(a_ready), 32'd0);
        chk({tag, " d@e3"}, 32'(a_d), 32'(data));
        tick();
        chk({tag, " ready@e4"}, 32'(a_ready), 32'd1);
        chk({tag, " busy@e4"}, 32'(a_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       hs;
        int         cyc, last_hs, idx, viol, w;
        logic [7:0] prev_d, prev_e, seen_e;
        logic [7:0] pulses [$];
        logic [2:0] bb_addr [3];
        logic [7:0] bb_data [3];
        logic [2:0] bad_addr [2];

        vecs[0] = '{3'd5, 8'hA5, 8'h20};
        vecs[1] = '{3'd0, 8'h11, 8'h01};
        vecs[2] = '{3'd7, 8'hFF, 8'h80};
        vecs[3] = '{3'd1, 8'h22, 8'h02};
        vecs[4] = '{3'd5, 8'h3C, 8'h20};
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;

        a_valid = 1'b1; a_addr = 3'd4; a_data = 8'hEE;
        b_valid = 1'b0; b_addr = 3'd0; b_data = 8'h00;
        c_valid = 1'b0; c_addr = 3'd0; c_data = 8'h00;

        // Reset with a request pending
        #1 RST = 1'b1;
        #2;
        chk("rst lat_e", 32'(a_e), 32'd0);
        chk("rst lat_d", 32'(a_d), 32'd0);
        chk("rst ready", 32'(a_ready), 32'd0);
        chk("rst busy", 32'(a_busy), 32'd0);
        tick();
        tick();
        chk("rst held lat_e", 32'(a_e), 32'd0);
        @(negedge CLK);
        RST     = 1'b0;
        a_valid = 1'b0;
        tick();
        chk("post-rst ready", 32'(a_ready), 32'd1);
        chk("post-rst lat_e", 32'(a_e), 32'd0);
        chk("post-rst err", 32'(a_err), 32'd0);

        // Vector table
        for (int i = 0; i < 5; i++) begin
            write_a(vecs[i].addr, vecs[i].data, vecs[i].exp_e, $sformatf("vec%0d", i));
            exp_mem[vecs[i].addr] = vecs[i].data;
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("latch word%0d", i), 32'(mem_a[i]), 32'(exp_mem[i]));
        end

        // Back-to-back with wr_valid held high
        bb_addr = '{3'd0, 3'd1, 3'd2};
        bb_data = '{8'h11, 8'h22, 8'h33};
        idx = 0; cyc = 0; last_hs = 0; viol = 0;
        pulses.delete();
        a_valid = 1'b1; a_addr = bb_addr[0]; a_data = bb_data[0];
        prev_d = a_d; prev_e = a_e;
        for (int k = 0; k < 60; k++) begin
            if (idx == 3 && !a_busy) break;
            hs = a_valid && a_ready;
            tick();
            cyc++;
            if (hs) begin
                if (idx > 0) chk($sformatf("b2b spacing%0d", idx), 32'(cyc - last_hs), 32'd5);
                last_hs = cyc;
                idx++;
                if (idx < 3) begin
                    a_addr = bb_addr[idx];
                    a_data = bb_data[idx];
                end else begin
                    a_valid = 1'b0;
                end
            end
            if ($countones(a_e) > 1) viol++;
            if (a_d != prev_d && (a_e != 8'h00 || prev_e != 8'h00)) viol++;
            if (a_e != 8'h00 && prev_e == 8'h00) pulses.push_back(a_e);
            prev_d = a_d;
            prev_e = a_e;
        end
        chk("b2b handshakes", 32'(idx), 32'd3);
        chk("b2b violations", 32'(viol), 32'd0);
        chk("b2b pulse count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            chk("b2b pulse0", 32'(pulses[0]), 32'h01);
            chk("b2b pulse1", 32'(pulses[1]), 32'h02);
            chk("b2b pulse2", 32'(pulses[2]), 32'h04);
        end
        chk("b2b word2", 32'(mem_a[2]), 32'h33);

        // Reset in the middle of the pulse
        tick();
        a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h99;
        tick();
        a_valid = 1'b0;
        tick();
        chk("midrst e@e1", 32'(a_e), 32'h08);
        tick();
        chk("midrst e@e2", 32'(a_e), 32'h08);
        #2 RST = 1'b1;
        #1;
        chk("midrst e async", 32'(a_e), 32'd0);
        chk("midrst busy async", 32'(a_busy), 32'd0);
        chk("midrst ready", 32'(a_ready), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        chk("midrst idle", 32'(a_busy), 32'd0);
        chk("midrst ready after", 32'(a_ready), 32'd1);
        chk("midrst kept word3", 32'(mem_a[3]), 32'h99);
        write_a(3'd3, 8'h5A, 8'h08, "post-midrst");
        chk("post-midrst word3", 32'(mem_a[3]), 32'h5A);

        // Out-of-range on the DEPTH=6 bank: addr 6 (first illegal) and 7
        bad_addr = '{3'd6, 3'd7};
        for (int i = 0; i < 2; i++) begin
            b_valid = 1'b1; b_addr = bad_addr[i]; b_data = 8'h70 + 8'(i);
            tick();
            b_valid = 1'b0;
            chk($sformatf("oor%0d err@e0", i), 32'(b_err), 32'd0);
            chk($sformatf("oor%0d d@e0", i), 32'(b_d), 32'(8'h70 + 8'(i)));
            tick();
            chk($sformatf("oor%0d err@e1", i), 32'(b_err), 32'd1);
            chk($sformatf("oor%0d e@e1", i), 32'(b_e), 32'd0);
            chk($sformatf("oor%0d ready@e1", i), 32'(b_ready), 32'd0);
            tick();
            chk($sformatf("oor%0d err@e2", i), 32'(b_err), 32'd0);
            chk($sformatf("oor%0d e@e2", i), 32'(b_e), 32'd0);
            chk($sformatf("oor%0d ready@e2", i), 32'(b_ready), 32'd1);
        end

        // Pulse width, PULSE_CYC=1
        b_valid = 1'b1; b_addr = 3'd5; b_data = 8'h5B;
        tick();
        b_valid = 1'b0;
        w = 0; seen_e = 8'h00;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (b_e != 6'd0) begin
                w++;
                seen_e = 8'(b_e);
            end else if (w > 0) begin
                break;
            end
        end
        chk("width P=1", 32'(w), 32'd1);
        chk("lines P=1", 32'(seen_e), 32'h20);
        chk("err P=1", 32'(b_err), 32'd0);

        // Pulse width, PULSE_CYC=15
        for (int j = 0; j < 2; j++) begin
            c_valid = 1'b1; c_addr = (j == 0) ? 3'd3 : 3'd7; c_data = 8'hC0 + 8'(j);
            tick();
            c_valid = 1'b0;
            w = 0; seen_e = 8'h00;
            for (int k = 0; k < 60; k++) begin
                tick();
                if (c_e != 8'd0) begin
                    w++;
                    seen_e = c_e;
                end else if (w > 0) begin
                    break;
                end
            end
            chk($sformatf("width P=15 #%0d", j), 32'(w), 32'd15);
            chk($sformatf("lines P=15 #%0d", j), 32'(seen_e), (j == 0) ? 32'h08 : 32'h80);
            chk($sformatf("err P=15 #%0d", j), 32'(c_err), 32'd0);
            tick();
            chk($sformatf("ready P=15 #%0d", j), 32'(c_ready), 32'd1);
            chk($sformatf("d P=15 #%0d", j), 32'(c_d), 32'(8'hC0 + 8'(j)));
        end
        chk("c idle busy", 32'(c_busy), 32'd0);
        chk("b idle busy", 32'(b_busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
